// File: rtl/nov2ph_monitor.sv
// nov2ph_monitor: oversampling checker for a non-overlapping two-phase clock
// pair. Synchronizes ph1/ph2, tracks phase order, measures both gaps and
// rebuilds a single-phase clock.
//
// state | meaning
// ------+------------------------------------------------------------
// SYNC  | waiting for both phases low before trusting the order
// IDLE  | both low after sync, no phase seen yet
// PH1   | ph1 high
// GAP12 | ph1 fell, waiting for ph2 (gap counter running)
// PH2   | ph2 high
// GAP21 | ph2 fell, waiting for ph1 (gap counter running)
module nov2ph_monitor #(
  parameter int CNT_W       = 8,
  parameter int MIN_NOV     = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ph1,
  input  logic             ph2,
  input  logic             err_clr,
  output logic             clk_rec,
  output logic [CNT_W-1:0] gap12,
  output logic [CNT_W-1:0] gap21,
  output logic             meas_valid,
  output logic             overlap_err,
  output logic             nov_err,
  output logic             seq_err
);

  typedef enum logic [2:0] {
    S_SYNC, S_IDLE, S_PH1, S_GAP12, S_PH2, S_GAP21
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_GAP = CNT_W'(MIN_NOV);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ph1_sync_q, ph1_sync_d;
  logic [SYNC_STAGES-1:0] ph2_sync_q, ph2_sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       gap12_q, gap12_d;
  logic [CNT_W-1:0]       gap21_q, gap21_d;
  logic                   half_q, half_d;
  logic                   clk_rec_q, clk_rec_d;
  logic                   meas_valid_q, meas_valid_d;
  logic                   overlap_err_q, overlap_err_d;
  logic                   nov_err_q, nov_err_d;
  logic                   seq_err_q, seq_err_d;
  logic                   ph1_s, ph2_s;
  logic                   ovl_set, nov_set, seq_set;

  assign ph1_s = ph1_sync_q[SYNC_STAGES-1];
  assign ph2_s = ph2_sync_q[SYNC_STAGES-1];

  // Shift the raw phases through the synchronizer chains.
  always_comb begin
    ph1_sync_d = {ph1_sync_q[SYNC_STAGES-2:0], ph1};
    ph2_sync_d = {ph2_sync_q[SYNC_STAGES-2:0], ph2};
  end

  // Phase-order tracking, gap measurement and error detection.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    half_d       = half_q;
    clk_rec_d    = clk_rec_q;
    gap12_d      = gap12_q;
    gap21_d      = gap21_q;
    meas_valid_d = 1'b0;
    ovl_set      = 1'b0;
    nov_set      = 1'b0;
    seq_set      = 1'b0;
    case (state_q)
      S_SYNC: begin
        if (!ph1_s && !ph2_s) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (ph1_s && ph2_s) begin
          ovl_set = 1'b1;
          state_d = S_SYNC;
        end else if (ph1_s) begin
          state_d = S_PH1;
        end else if (ph2_s) begin
          state_d = S_PH2;
        end
      end
      S_PH1: begin
        if (ph2_s) begin
          ovl_set = 1'b1;
          state_d = S_SYNC;
        end else if (!ph1_s) begin
          state_d   = S_GAP12;
          cnt_d     = CNT_ONE;
          clk_rec_d = 1'b0;
        end
      end
      S_GAP12: begin
        if (ph1_s && ph2_s) begin
          ovl_set = 1'b1;
          state_d = S_SYNC;
        end else if (ph2_s) begin
          gap12_d = cnt_q;
          nov_set = (cnt_q < MIN_GAP);
          half_d  = 1'b1;
          state_d = S_PH2;
        end else if (ph1_s) begin
          seq_set = 1'b1;
          half_d  = 1'b0;
          state_d = S_PH1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_PH2: begin
        if (ph1_s) begin
          ovl_set = 1'b1;
          state_d = S_SYNC;
        end else if (!ph2_s) begin
          state_d   = S_GAP21;
          cnt_d     = CNT_ONE;
          clk_rec_d = 1'b1;
        end
      end
      S_GAP21: begin
        if (ph1_s && ph2_s) begin
          ovl_set = 1'b1;
          state_d = S_SYNC;
        end else if (ph1_s) begin
          gap21_d      = cnt_q;
          nov_set      = (cnt_q < MIN_GAP);
          meas_valid_d = half_q;
          half_d       = 1'b0;
          state_d      = S_PH1;
        end else if (ph2_s) begin
          seq_set = 1'b1;
          half_d  = 1'b0;
          state_d = S_PH2;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = S_SYNC;
    endcase
    // A resync throws away any half-finished measurement.
    if (state_d == S_SYNC) half_d = 1'b0;
    // Sticky flags: a new error in the clear cycle wins over the clear.
    overlap_err_d = (overlap_err_q & ~err_clr) | ovl_set;
    nov_err_d     = (nov_err_q & ~err_clr) | nov_set;
    seq_err_d     = (seq_err_q & ~err_clr) | seq_set;
  end

  // State, measurement and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_SYNC;
      ph1_sync_q    <= '0;
      ph2_sync_q    <= '0;
      cnt_q         <= '0;
      half_q        <= 1'b0;
      clk_rec_q     <= 1'b0;
      gap12_q       <= '0;
      gap21_q       <= '0;
      meas_valid_q  <= 1'b0;
      overlap_err_q <= 1'b0;
      nov_err_q     <= 1'b0;
      seq_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ph1_sync_q    <= ph1_sync_d;
      ph2_sync_q    <= ph2_sync_d;
      cnt_q         <= cnt_d;
      half_q        <= half_d;
      clk_rec_q     <= clk_rec_d;
      gap12_q       <= gap12_d;
      gap21_q       <= gap21_d;
      meas_valid_q  <= meas_valid_d;
      overlap_err_q <= overlap_err_d;
      nov_err_q     <= nov_err_d;
      seq_err_q     <= seq_err_d;
    end
  end

  assign clk_rec     = clk_rec_q;
  assign gap12       = gap12_q;
  assign gap21       = gap21_q;
  assign meas_valid  = meas_valid_q;
  assign overlap_err = overlap_err_q;
  assign nov_err     = nov_err_q;
  assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_nov2ph_monitor.sv
// Bench for nov2ph_monitor: directed two-phase waveforms followed by random
// periods, every cycle compared against a phase-history reference model.
module tb_nov2ph_monitor;

  localparam int CNT_W       = 8;
  localparam int MIN_NOV     = 2;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_CAP     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ph1 = 1'b0;
  logic             ph2 = 1'b0;
  logic             err_clr = 1'b0;
  logic             clk_rec;
  logic [CNT_W-1:0] gap12;
  logic [CNT_W-1:0] gap21;
  logic             meas_valid;
  logic             overlap_err;
  logic             nov_err;
  logic             seq_err;

  nov2ph_monitor #(
    .CNT_W(CNT_W), .MIN_NOV(MIN_NOV), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .ph1(ph1), .ph2(ph2), .err_clr(err_clr),
    .clk_rec(clk_rec), .gap12(gap12), .gap21(gap21), .meas_valid(meas_valid),
    .overlap_err(overlap_err), .nov_err(nov_err), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mv_count = 0;

  // Pin history: the monitor acts on what was on the pins SYNC_STAGES edges ago.
  logic [1:0] hist[$];

  // Reference model: which phase is high now, which one was high last,
  // how long the current gap has lasted, and whether a clean first half
  // period has been seen.
  bit m_locked;
  int m_cur, m_last, m_gap;
  bit m_half;
  int e_clk_rec, e_gap12, e_gap21, e_mv, e_ovl, e_nov, e_seq;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_cur = 0; m_last = 0; m_gap = 0; m_half = 0;
    e_clk_rec = 0; e_gap12 = 0; e_gap21 = 0; e_mv = 0;
    e_ovl = 0; e_nov = 0; e_seq = 0;
    hist.delete();
    for (int i = 0; i < SYNC_STAGES; i++) hist.push_back(2'b00);
  endtask

  task automatic model_unlock();
    m_locked = 0; m_half = 0; m_cur = 0; m_last = 0;
  endtask

  task automatic model_step(input bit a, input bit b, input bit clr);
    bit ovl, nov, sq;
    int ph, other, lat;
    ovl = 0; nov = 0; sq = 0;
    e_mv = 0;
    if (!m_locked) begin
      if (!a && !b) begin
        m_locked = 1; m_cur = 0; m_last = 0;
      end
    end else if (a && b) begin
      ovl = 1;
      model_unlock();
    end else if (a || b) begin
      ph    = a ? 1 : 2;
      other = a ? 2 : 1;
      if (m_cur == other) begin
        ovl = 1;
        model_unlock();
      end else if (m_cur == 0) begin
        if (m_last == ph) begin
          sq = 1;
          m_half = 0;
        end else if (m_last == other) begin
          lat = (m_gap > CNT_CAP) ? CNT_CAP : m_gap;
          if (lat < MIN_NOV) nov = 1;
          if (ph == 2) begin
            e_gap12 = lat;
            m_half = 1;
          end else begin
            e_gap21 = lat;
            e_mv = int'(m_half);
            m_half = 0;
          end
        end
        m_cur = ph;
        m_last = ph;
      end
    end else begin
      if (m_cur != 0) begin
        e_clk_rec = (m_cur == 2) ? 1 : 0;
        m_last = m_cur;
        m_cur = 0;
        m_gap = 1;
      end else if (m_last != 0) begin
        m_gap++;
      end
    end
    e_ovl = ((e_ovl != 0 && !clr) || ovl) ? 1 : 0;
    e_nov = ((e_nov != 0 && !clr) || nov) ? 1 : 0;
    e_seq = ((e_seq != 0 && !clr) || sq) ? 1 : 0;
  endtask

  task automatic compare_all();
    check("clk_rec", int'(clk_rec), e_clk_rec);
    check("gap12", int'(gap12), e_gap12);
    check("gap21", int'(gap21), e_gap21);
    check("meas_valid", int'(meas_valid), e_mv);
    check("overlap_err", int'(overlap_err), e_ovl);
    check("nov_err", int'(nov_err), e_nov);
    check("seq_err", int'(seq_err), e_seq);
    if (meas_valid === 1'b1) mv_count++;
  endtask

  task automatic step(input bit p1, input bit p2, input bit clr);
    logic [1:0] s;
    @(negedge clk);
    rst = 1'b0; ph1 = p1; ph2 = p2; err_clr = clr;
    hist.push_back({p1, p2});
    s = hist.pop_front();
    @(posedge clk);
    model_step(s[1], s[0], clr);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; err_clr = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    compare_all();
  endtask

  task automatic run(input bit p1, input bit p2, input int n);
    for (int i = 0; i < n; i++) step(p1, p2, 1'b0);
  endtask

  task automatic period(input int h1, input int g12, input int h2, input int g21);
    run(1, 0, h1); run(0, 0, g12); run(0, 1, h2); run(0, 0, g21);
  endtask

  initial begin
    // Reset state
    do_reset();
    do_reset();
    check("rst_gap12", int'(gap12), 0);
    check("rst_flags", int'({overlap_err, nov_err, seq_err, meas_valid, clk_rec}), 0);
    run(0, 0, 4);

    // Nominal 20-cycle period
    mv_count = 0;
    repeat (4) period(7, 3, 7, 3);
    run(1, 0, 7);
    check("nom_gap12", int'(gap12), 3);
    check("nom_gap21", int'(gap21), 3);
    check("nom_mv_count", mv_count, 4);
    check("nom_clk_rec", int'(clk_rec), 1);
    check("nom_errs", int'({overlap_err, nov_err, seq_err}), 0);

    // Overlap while ph1 high
    step(1, 1, 0);
    step(1, 1, 0);
    check("ovl_lat_early", int'(overlap_err), 0);
    step(1, 1, 0);
    check("ovl_lat", int'(overlap_err), 1);
    step(1, 1, 0);
    run(1, 0, 3);
    run(0, 0, 5);
    mv_count = 0;
    period(7, 3, 7, 3);
    check("ovl_no_mv", mv_count, 0);
    run(1, 0, 7);
    check("ovl_mv_after_clean", mv_count, 1);
    step(1, 0, 1);
    check("ovl_clr", int'(overlap_err), 0);

    // Short gap12 of one cycle
    mv_count = 0;
    run(0, 0, 1); run(0, 1, 7); run(0, 0, 3); run(1, 0, 7);
    check("short_gap12", int'(gap12), 1);
    check("short_nov", int'(nov_err), 1);
    check("short_mv", mv_count, 1);

    // ph1 re-asserted with no ph2 in between
    mv_count = 0;
    run(0, 0, 3); run(1, 0, 7);
    check("seq_err", int'(seq_err), 1);
    check("seq_gap12_held", int'(gap12), 1);
    check("seq_no_mv", mv_count, 0);
    run(0, 0, 3); run(0, 1, 7); run(0, 0, 3); run(1, 0, 7);
    check("seq_recover_gap12", int'(gap12), 3);

    // gap21 saturation
    run(0, 0, 3); run(0, 1, 7); run(0, 0, 300); run(1, 0, 7);
    check("sat_gap21", int'(gap21), CNT_CAP);

    // Reset in the middle of GAP12, then nominal periods
    run(0, 0, 2);
    do_reset();
    check("mid_rst_gaps", int'({gap12, gap21}), 0);
    check("mid_rst_flags", int'({overlap_err, nov_err, seq_err, meas_valid, clk_rec}), 0);
    mv_count = 0;
    run(0, 0, 3);
    period(7, 3, 7, 3);
    check("post_rst_no_mv", mv_count, 0);
    run(1, 0, 7);
    check("post_rst_first_mv", mv_count, 1);
    run(0, 0, 3); run(0, 1, 7); run(0, 0, 3);

    // Random periods with occasional overlap and random clears
    for (int i = 0; i < 60; i++) begin
      int h1, g12, h2, g21;
      h1  = $urandom_range(1, 9);
      g12 = $urandom_range(0, 4);
      h2  = $urandom_range(1, 9);
      g21 = $urandom_range(0, 4);
      for (int k = 0; k < h1; k++) step(1, 0, ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 7) == 0) run(1, 1, $urandom_range(1, 3));
      for (int k = 0; k < g12; k++) step(0, 0, ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 9) == 0) run(1, 0, $urandom_range(1, 4));
      for (int k = 0; k < h2; k++) step(0, 1, ($urandom_range(0, 15) == 0));
      for (int k = 0; k < g21; k++) step(0, 0, ($urandom_range(0, 15) == 0));
    end
    run(0, 0, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
